sram_dp_be_clr: RTL

//  Parametrised successor to the team's single-port synchronous SRAM.
//  - Separate write and read ports, per-byte write enables, selectable read-during-write mode.
//  - Optional output register.
//  - Built-in clear sequencer: fills memory with a known value after reset.

---
 rtl/sram_v_pkg.sv | 32 +++
 rtl/sram_clr_seq.sv | 64 ++++++
 rtl/sram_dp_be_clr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sram_v_pkg.sv
// Shared types and helpers for the dual-port byte-enable SRAM with clear sequencer.
package sram_v_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Read-during-write behaviour selectors for the RDW_MODE parameter
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // The merge helper works on the widest supported word; callers zero-extend
   // their operands and truncate the result back to their own width.
   localparam int MAX_N  = 1024;
   localparam int MAX_BE = MAX_N / 8;

   // Byte-wise merge: enabled bytes come from new_w, the rest from old_w.
   function automatic logic [MAX_N-1:0] merge_be(
      input logic [MAX_N-1:0]  old_w,
      input logic [MAX_N-1:0]  new_w,
      input logic [MAX_BE-1:0] be
   );
      logic [MAX_N-1:0] res;
      res = old_w;
      for (int k = 0; k < MAX_BE; k++) begin
         if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Clear sequencer: walks every word once after reset, then releases the memory.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  CLEAR | writing CLR_VAL to word clr_cnt, one word per cycle; busy
//  READY | clear done; user ports own the memory until next reset
//
module sram_clr_seq
   import sram_v_pkg::*;
#(
   parameter int M     = 10,
   parameter int DEPTH = 2**M
) (
   input  logic         i_clk,
   input  logic         i_rst,
   output logic         clr_we,
   output logic [M-1:0] clr_addr,
   output logic         busy
);

   state_e       state, state_nxt;
   logic [M-1:0] clr_cnt, clr_cnt_nxt;

   // State and counter register; reset (including mid-clear) restarts the walk at word 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // Next state: advance one word per cycle, leave CLEAR after the last word
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         CLEAR: begin
            clr_cnt_nxt = clr_cnt + M'(1);
            if (clr_cnt == M'(DEPTH - 1)) begin
               state_nxt   = READY;
               clr_cnt_nxt = '0;
            end
         end
         READY: begin
            state_nxt = READY;
         end
         default: begin
            state_nxt   = CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // Outputs: busy also covers the reset cycles themselves so no request slips through
   always_comb begin
      clr_we   = (state == CLEAR) && !i_rst;
      clr_addr = clr_cnt;
      busy     = (state != READY) || i_rst;
   end

endmodule

// File: rtl/sram_dp_be_clr.sv
// Dual-port (one write, one read) SRAM with byte enables, selectable
// read-during-write behaviour, optional output register and a built-in
// clear sequencer that fills the array with CLR_VAL after every reset.
module sram_dp_be_clr
   import sram_v_pkg::*;
#(
   parameter int           N        = 16,
   parameter int           M        = 10,
   parameter int           DEPTH    = 2**M,
   parameter int           RDW_MODE = RDW_OLD,
   parameter int           OUT_REG  = 0,
   parameter logic [N-1:0] CLR_VAL  = '0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           wr_en,
   input  logic [M-1:0]   wr_addr,
   input  logic [N/8-1:0] wr_be,
   input  logic [N-1:0]   d_in,
   input  logic           rd_en,
   input  logic [M-1:0]   rd_addr,
   output logic [N-1:0]   data_out,
   output logic           rd_valid,
   output logic           addr_err,
   output logic           busy
);

   logic [N-1:0] mem [DEPTH];

   logic         clr_we;
   logic [M-1:0] clr_addr;
   logic         seq_busy;

   logic         wr_acc, rd_acc;
   logic         wr_oob, rd_oob;
   logic         wr_word_ok;
   logic [N-1:0] wr_merged;
   logic [N-1:0] rd_word;

   logic         a_valid, a_err, w_err;
   logic [N-1:0] a_data;

   sram_clr_seq #(
      .M     (M),
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .busy     (seq_busy)
   );

   assign busy = seq_busy;

   // Request qualification and range checks; DEPTH may be smaller than 2**M
   always_comb begin
      wr_acc     = wr_en && !seq_busy;
      rd_acc     = rd_en && !seq_busy;
      wr_oob     = 32'(wr_addr) >= 32'(DEPTH);
      rd_oob     = 32'(rd_addr) >= 32'(DEPTH);
      wr_word_ok = wr_acc && !wr_oob;
      wr_merged  = N'(merge_be(MAX_N'(mem[wr_addr]), MAX_N'(d_in), MAX_BE'(wr_be)));
   end

   // Read word: out-of-range reads return zero; same-address bypass only in RDW_NEW mode
   always_comb begin
      rd_word = '0;
      if (!rd_oob) begin
         rd_word = mem[rd_addr];
         if (RDW_MODE == RDW_NEW && wr_word_ok && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
         end
      end
   end

   // Memory write mux: the clear port owns the array while busy, user writes otherwise
   always_ff @(posedge i_clk) begin
      if (clr_we) begin
         mem[clr_addr] <= CLR_VAL;
      end else if (wr_word_ok) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   // First read stage plus write-error flag; data only loads on an accepted read so it holds
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_valid <= 1'b0;
         a_err   <= 1'b0;
         a_data  <= '0;
         w_err   <= 1'b0;
      end else begin
         a_valid <= rd_acc;
         a_err   <= rd_acc && rd_oob;
         w_err   <= wr_acc && wr_oob;
         if (rd_acc) a_data <= rd_word;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic         b_valid, b_err;
         logic [N-1:0] b_data;

         // Extra output stage; valid bits travel alongside so data never gates rd_valid
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               b_valid <= 1'b0;
               b_err   <= 1'b0;
               b_data  <= '0;
            end else begin
               b_valid <= a_valid;
               b_err   <= a_err;
               if (a_valid) b_data <= a_data;
            end
         end

         assign data_out = b_data;
         assign rd_valid = b_valid;
         assign addr_err = b_err || w_err;
      end else begin : g_no_out_reg
         assign data_out = a_data;
         assign rd_valid = a_valid;
         assign addr_err = a_err || w_err;
      end
   endgenerate

endmodule
